// File: rtl/pbit_sweep_scheduler.sv
// Sequences one-hot p-bit update enables through repeated sweeps, snapshots the
// p-bit vector after each sweep behind a valid/ready handshake, and anneals beta.
module pbit_sweep_scheduler #(
    parameter int NPB         = 5,
    parameter int EN_CYC      = 2,
    parameter int GAP         = 1,
    parameter int BETA_PERIOD = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      num_sweeps,
    input  logic [3:0]       beta_init,
    input  logic [NPB-1:0]   pbit_state,
    output logic [NPB-1:0]   en,
    output logic [3:0]       beta,
    output logic [NPB-1:0]   sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [15:0]      sweep_cnt,
    output logic             busy,
    output logic             done
);

    localparam int SLOT_W   = (NPB > 1) ? $clog2(NPB) : 1;
    localparam int CYC_MAX  = (EN_CYC > GAP) ? EN_CYC : ((GAP > 1) ? GAP : 1);
    localparam int CYC_W    = $clog2(CYC_MAX + 1);
    localparam int BDIV_W   = $clog2(BETA_PERIOD + 1);
    localparam int EN_LAST  = EN_CYC - 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [2:0] {
        IDLE, ARM, UPD, GAPW, SAMPLE, DONE
    } state_t;

    state_t              state, state_nx;
    logic [SLOT_W-1:0]   slot;
    logic [CYC_W-1:0]    cyc;
    logic [BDIV_W-1:0]   bdiv;
    logic [15:0]         target;
    logic                slot_inc;
    logic                last_slot;
    logic                handshake;

    function automatic logic [3:0] beta_sat_inc(input logic [3:0] b);
        return (b == 4'd15) ? b : b + 4'd1;
    endfunction

    assign last_slot = (slot == SLOT_W'(NPB - 1));
    assign handshake = (state == SAMPLE) && sample_valid && sample_ready && !abort;
    assign en        = (state == UPD) ? (NPB'(1) << slot) : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        slot_inc = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = (num_sweeps == 16'd0) ? DONE : ARM;
            ARM:    state_nx = UPD;
            UPD: begin
                if (cyc == CYC_W'(EN_LAST)) begin
                    if (GAP > 0) begin
                        state_nx = GAPW;
                    end else if (last_slot) begin
                        state_nx = SAMPLE;
                    end else begin
                        state_nx = UPD;
                        slot_inc = 1'b1;
                    end
                end
            end
            GAPW: begin
                if (cyc == CYC_W'(GAP_LAST)) begin
                    if (last_slot) begin
                        state_nx = SAMPLE;
                    end else begin
                        state_nx = UPD;
                        slot_inc = 1'b1;
                    end
                end
            end
            SAMPLE: if (handshake) state_nx = (sweep_cnt + 16'd1 == target) ? DONE : UPD;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort wins over every other transition, including a pending handshake.
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            slot         <= '0;
            cyc          <= '0;
            bdiv         <= '0;
            target       <= '0;
            beta         <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sweep_cnt    <= '0;
            done         <= 1'b0;
        end else begin
            state <= state_nx;
            // done is registered, so the pulse lands the cycle after DONE.
            done  <= (state == DONE) && !abort;

            if (state_nx != state || slot_inc) cyc <= '0;
            else                               cyc <= cyc + 1'b1;

            if (slot_inc)
                slot <= slot + 1'b1;
            else if (state_nx == UPD && state != UPD && state != GAPW)
                slot <= '0;

            if (state == IDLE && start) begin
                target    <= num_sweeps;
                beta      <= beta_init;
                sweep_cnt <= '0;
                bdiv      <= '0;
            end

            if (state_nx == SAMPLE && state != SAMPLE) begin
                sample_data  <= pbit_state;
                sample_valid <= 1'b1;
            end

            if (handshake) begin
                sample_valid <= 1'b0;
                sweep_cnt    <= sweep_cnt + 16'd1;
                if (bdiv == BDIV_W'(BETA_PERIOD - 1)) begin
                    bdiv <= '0;
                    beta <= beta_sat_inc(beta);
                end else begin
                    bdiv <= bdiv + 1'b1;
                end
            end

            if (abort && state != IDLE) sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Randomized bench for pbit_sweep_scheduler: a position-based sweep model
// feeds sample and run-result scoreboards that a negedge monitor drains.
module tb_pbit_sweep_scheduler;

    localparam int NPB = 5;
    localparam int EN_CYC = 2;
    localparam int GAP = 1;
    localparam int BP = 4;
    localparam int SLOT_LEN = EN_CYC + GAP;
    localparam int SWP = NPB * SLOT_LEN;   // position SWP is the sample phase
    localparam int BUDGET = 4000;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [15:0]      num_sweeps = '0;
    logic [3:0]       beta_init = '0;
    logic [NPB-1:0]   pbit_state = '0;
    logic [NPB-1:0]   en;
    logic [3:0]       beta;
    logic [NPB-1:0]   sample_data;
    logic             sample_valid;
    logic             sample_ready = 1'b1;
    logic [15:0]      sweep_cnt;
    logic             busy;
    logic             done;

    pbit_sweep_scheduler #(.NPB(NPB), .EN_CYC(EN_CYC), .GAP(GAP), .BETA_PERIOD(BP)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort),
        .num_sweeps(num_sweeps), .beta_init(beta_init), .pbit_state(pbit_state),
        .en(en), .beta(beta), .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sweep_cnt(sweep_cnt), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 running, 2 finishing; pos -1 is the arm cycle.
    int             ph = 0;
    int             pos = 0;
    int             m_cnt = 0;
    int             m_tgt = 0;
    int             m_beta = 0;
    logic [NPB-1:0] m_data = '0;
    bit             m_sv = 0;
    bit             m_done = 0;
    logic [NPB-1:0] sq[$];
    int             rq_cnt[$];
    int             rq_beta[$];

    function automatic logic [NPB-1:0] exp_en();
        if (ph == 1 && pos >= 0 && pos < SWP && (pos % SLOT_LEN) < EN_CYC)
            return NPB'(1) << (pos / SLOT_LEN);
        return '0;
    endfunction

    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                ph = 0; pos = 0; m_cnt = 0; m_tgt = 0; m_beta = 0;
                m_data = '0; m_sv = 0; m_done = 0;
                sq.delete();
            end else begin
                m_done = 0;
                case (ph)
                    0: if (start) begin
                        m_tgt = num_sweeps; m_beta = beta_init; m_cnt = 0;
                        if (m_tgt == 0) ph = 2;
                        else begin ph = 1; pos = -1; end
                    end
                    2: begin ph = 0; m_done = !abort; end
                    default: begin
                        if (abort) begin
                            ph = 0;
                            if (m_sv) void'(sq.pop_back());
                            m_sv = 0;
                        end else if (pos < SWP) begin
                            pos++;
                            if (pos == SWP) begin
                                m_data = pbit_state; m_sv = 1;
                                sq.push_back(pbit_state);
                            end
                        end else if (sample_ready) begin
                            m_sv = 0; m_cnt++;
                            if (m_cnt % BP == 0 && m_beta < 15) m_beta++;
                            if (m_cnt == m_tgt) ph = 2;
                            else pos = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: per-cycle comparison plus scoreboard pops on handshake and done.
    initial begin
        forever begin
            @(negedge CLK);
            chk("en", en, exp_en());
            chk("busy", busy, ph != 0);
            chk("done", done, m_done);
            chk("beta", beta, m_beta);
            chk("sweep_cnt", sweep_cnt, m_cnt);
            chk("sample_valid", sample_valid, m_sv);
            chk("sample_data", sample_data, m_data);
            if (RST && sample_valid && sample_ready && !abort) begin
                if (sq.size() == 0) chk("sample_unexpected", 1, 0);
                else chk("sample_sb", sample_data, sq.pop_front());
            end
            if (done) begin
                if (rq_cnt.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("run_sweep_cnt", sweep_cnt, rq_cnt.pop_front());
                    chk("run_beta", beta, rq_beta.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK); #2;
            pbit_state = NPB'($urandom);
        end
    end

    // rmode: 0 ready high, 1 random ready, 2 ready low for 10 cycles of first SAMPLE
    task automatic run_seq(input int ns, input int bi, input int rmode, input bit do_abort);
        int c = 0;
        int lowc = 0;
        bit aborted = 0;
        int eb;
        @(posedge CLK); #2;
        num_sweeps = 16'(ns);
        beta_init = 4'(bi);
        start = 1'b1;
        sample_ready = 1'b1;
        if (!do_abort) begin
            eb = bi + ns / BP;
            rq_cnt.push_back(ns);
            rq_beta.push_back(eb > 15 ? 15 : eb);
        end
        @(posedge CLK); #2;
        start = 1'b0;
        while (busy && c < BUDGET) begin
            case (rmode)
                0: sample_ready = 1'b1;
                1: sample_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (sample_valid && lowc < 10) begin sample_ready = 1'b0; lowc++; end
                    else sample_ready = 1'b1;
                end
            endcase
            start = ($urandom_range(0, 7) == 0);
            if (do_abort && !aborted && sweep_cnt == 0 && en == 5'b00100) begin
                abort = 1'b1;
                aborted = 1;
            end
            @(posedge CLK); #2;
            abort = 1'b0;
            c++;
        end
        start = 1'b0;
        sample_ready = 1'b1;
        if (c >= BUDGET) chk("run_timeout", 1, 0);
        repeat (2) @(posedge CLK);
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #2;
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        run_seq(2, 3, 0, 0);
        run_seq(8, 14, 0, 0);
        run_seq(3, 5, 2, 0);
        run_seq(0, 7, 0, 0);
        run_seq(3, 1, 0, 1);
        run_seq(1, 2, 0, 0);

        // Reset mid-run during an update cycle, with start held during reset.
        begin
            int c = 0;
            @(posedge CLK); #2;
            num_sweeps = 16'd2; beta_init = 4'd9; start = 1'b1;
            @(posedge CLK); #2;
            start = 1'b0;
            while (en == '0 && c < 20) begin @(posedge CLK); #2; c++; end
            chk("rst_run_reached_upd", (en != '0), 1);
            RST = 1'b0;
            #1;
            chk("async_rst_en", en, 0);
            chk("async_rst_busy", busy, 0);
            chk("async_rst_beta", beta, 0);
            chk("async_rst_valid", sample_valid, 0);
            chk("async_rst_cnt", sweep_cnt, 0);
            start = 1'b1;
            @(posedge CLK); #2;
            start = 1'b0;
            RST = 1'b1;
            repeat (4) @(posedge CLK);
            #2;
            chk("post_rst_idle", busy, 0);
        end

        for (int i = 0; i < 6; i++)
            run_seq($urandom_range(1, 5), $urandom_range(0, 15), 1, 0);

        repeat (3) @(posedge CLK);
        chk("sample_q_empty", sq.size(), 0);
        chk("run_q_empty", rq_cnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
